// File: rtl/pipe_ctrl_pkg.sv
// Purpose : shared stall-vector encodings, FSM state type and stall merge helper for pipe_ctrl.
// Latency : n/a (types, constants and a pure function only).
// Backpres: n/a.
// Contents: STOP level, STALL_* vectors (bit0 PC .. bit5 WB), pipe_state_e, stall_merge().
package pipe_ctrl_pkg;

  // A stall bit at STOP means the stage holds its register this cycle.
  localparam logic STOP = 1'b1;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_REDIR = 2'd2
  } pipe_state_e;

  // The deepest requesting stage wins: it freezes itself and everything upstream.
  function automatic logic [5:0] stall_merge(input logic req_id, input logic req_ex,
                                             input logic req_mem);
    logic [5:0] vec;
    vec = STALL_NONE;
    if (req_mem)     vec = STALL_MEM;
    else if (req_ex) vec = STALL_EX;
    else if (req_id) vec = STALL_ID;
    return vec;
  endfunction

endpackage

// File: rtl/pipe_stall_wdt.sv
// Purpose : stall watchdog, counts consecutive stalled cycles and raises a sticky timeout flag.
// Latency : flag rises one edge after the count reaches MAX_STALL_CYCLES.
// Backpres: none; observes the stall vector only.
// Ports   : clk_in, reset_in (sync, active-high), stall_active (stall_out != 0), stall_timeout (sticky).
module pipe_stall_wdt #(
  parameter int unsigned MAX_STALL_CYCLES = 1024
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic stall_active,
  output logic stall_timeout
);

  localparam int unsigned CW = $clog2(MAX_STALL_CYCLES + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_STALL_CYCLES);

  logic [CW-1:0] stall_cnt;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      // Any free-running cycle restarts the count; saturate so a long stall cannot wrap.
      if (!stall_active)
        stall_cnt <= '0;
      else if (stall_cnt != MAX_CNT)
        stall_cnt <= stall_cnt + 1'b1;
      if (stall_cnt == MAX_CNT)
        stall_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Purpose : rv32i pipeline control: merges stall requests, issues and replays jump/flush redirects.
// Latency : stall vector and unblocked redirect are combinational (0 cycles); blocked redirect replays
//           the cycle after the last stalled cycle. Backpres: a redirect hitting an EX/MEM stall is held.
// Ports   : clk_in, reset_in (sync, active-high), stallreq_{id,ex,mem}_in, branch_req_in/branch_addr_in,
//           stall_out[5:0] (bit0 PC .. bit5 WB), jump_flush_out, jump_address_out, stall_timeout_out.
// Config  : PIPE_CTRL_WDT_EN compiles in the stall watchdog; otherwise stall_timeout_out is tied low.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned MAX_STALL_CYCLES = 1024
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  stallreq_id_in,
  input  logic                  stallreq_ex_in,
  input  logic                  stallreq_mem_in,
  input  logic                  branch_req_in,
  input  logic [ADDR_WIDTH-1:0] branch_addr_in,
  output logic [5:0]            stall_out,
  output logic                  jump_flush_out,
  output logic [ADDR_WIDTH-1:0] jump_address_out,
  output logic                  stall_timeout_out
);

  pipe_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [5:0]            req_vec;
  logic                  blocked;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= ST_RUN;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  always_comb begin
    req_vec          = stall_merge(stallreq_id_in, stallreq_ex_in, stallreq_mem_in);
    // Only EX/MEM freeze the stage that resolves branches; an ID hazard never blocks a redirect.
    blocked          = stallreq_ex_in | stallreq_mem_in;
    state_d          = state_q;
    pend_addr_d      = pend_addr_q;
    stall_out        = req_vec;
    jump_flush_out   = 1'b0;
    jump_address_out = '0;

    unique case (state_q)
      ST_RUN: begin
        if (branch_req_in) begin
          if (!blocked) begin
            jump_flush_out   = 1'b1;
            jump_address_out = branch_addr_in;
            // The ID load-use request belongs to the wrong path being flushed.
            stall_out        = {req_vec[5:3], 3'b000};
          end else begin
            pend_addr_d = branch_addr_in;
            state_d     = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        // EX is frozen here, so branch_req_in cannot be genuine and is ignored.
        if (!blocked) state_d = ST_REDIR;
      end
      ST_REDIR: begin
        jump_flush_out   = 1'b1;
        jump_address_out = pend_addr_q;
        stall_out        = STALL_NONE;
        state_d          = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // Outputs read as their reset values while reset is held.
    if (reset_in) begin
      stall_out        = STALL_NONE;
      jump_flush_out   = 1'b0;
      jump_address_out = '0;
      state_d          = ST_RUN;
    end
  end

`ifdef PIPE_CTRL_WDT_EN
  pipe_stall_wdt #(
    .MAX_STALL_CYCLES(MAX_STALL_CYCLES)
  ) u_wdt (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .stall_active  (stall_out != STALL_NONE),
    .stall_timeout (stall_timeout_out)
  );
`else
  // Threshold is meaningless without the watchdog; keep it referenced so it is not flagged as dead.
  logic cfg_unused;
  assign cfg_unused        = (MAX_STALL_CYCLES == 0);
  assign stall_timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int AW  = 32;
  localparam int MAX = 8;
`ifdef PIPE_CTRL_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          reset_in = 1'b1;
  logic          stallreq_id_in = 1'b0, stallreq_ex_in = 1'b0, stallreq_mem_in = 1'b0;
  logic          branch_req_in = 1'b0;
  logic [AW-1:0] branch_addr_in = '0;
  logic [5:0]    stall_out;
  logic          jump_flush_out;
  logic [AW-1:0] jump_address_out;
  logic          stall_timeout_out;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.ADDR_WIDTH(AW), .MAX_STALL_CYCLES(MAX)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .stallreq_id_in(stallreq_id_in), .stallreq_ex_in(stallreq_ex_in),
    .stallreq_mem_in(stallreq_mem_in), .branch_req_in(branch_req_in),
    .branch_addr_in(branch_addr_in), .stall_out(stall_out),
    .jump_flush_out(jump_flush_out), .jump_address_out(jump_address_out),
    .stall_timeout_out(stall_timeout_out)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- behavioural model ----------------
  // A "held" branch waits for EX/MEM to clear; the cycle after it clears, it is replayed.
  bit          m_held = 1'b0;
  bit          m_replay = 1'b0;
  logic [AW-1:0] m_addr = '0;
  int          m_run = 0;
  bit          m_to = 1'b0;

  typedef struct packed {
    logic [5:0]    stall;
    logic          flush;
    logic [AW-1:0] addr;
    logic          to;
  } exp_t;

  function automatic exp_t model_out();
    exp_t e;
    logic [5:0] want;
    if (stallreq_mem_in)     want = 6'h1F;
    else if (stallreq_ex_in) want = 6'h0F;
    else if (stallreq_id_in) want = 6'h07;
    else                     want = 6'h00;
    e.stall = want;
    e.flush = 1'b0;
    e.addr  = '0;
    e.to    = WDT & m_to;
    if (reset_in) begin
      e.stall = 6'h00;
    end else if (m_replay) begin
      e.flush = 1'b1; e.addr = m_addr; e.stall = 6'h00;
    end else if (!m_held && branch_req_in && !(stallreq_ex_in || stallreq_mem_in)) begin
      e.flush = 1'b1; e.addr = branch_addr_in; e.stall = want & 6'h38;
    end
    return e;
  endfunction

  always @(posedge clk_in) begin
    exp_t e;
    e = model_out();
    if (reset_in) begin
      m_held <= 1'b0; m_replay <= 1'b0; m_run <= 0; m_to <= 1'b0;
    end else begin
      if (m_run >= MAX) m_to <= 1'b1;
      m_run <= (e.stall != 0) ? ((m_run < MAX) ? m_run + 1 : m_run) : 0;
      if (m_replay) m_replay <= 1'b0;
      else if (m_held) begin
        if (!(stallreq_ex_in || stallreq_mem_in)) begin m_held <= 1'b0; m_replay <= 1'b1; end
      end else if (branch_req_in && (stallreq_ex_in || stallreq_mem_in)) begin
        m_held <= 1'b1; m_addr <= branch_addr_in;
      end
    end
  end

  // Compare process: every cycle, sampled on the falling edge.
  always @(negedge clk_in) begin
    exp_t e;
    e = model_out();
    checks += 4;
    if (stall_out !== e.stall) begin
      errors++; $display("FAIL model_stall t=%0t got=%h want=%h", $time, stall_out, e.stall);
    end
    if (jump_flush_out !== e.flush) begin
      errors++; $display("FAIL model_flush t=%0t got=%b want=%b", $time, jump_flush_out, e.flush);
    end
    if (jump_address_out !== e.addr) begin
      errors++; $display("FAIL model_addr t=%0t got=%h want=%h", $time, jump_address_out, e.addr);
    end
    if (stall_timeout_out !== e.to) begin
      errors++; $display("FAIL model_timeout t=%0t got=%b want=%b", $time, stall_timeout_out, e.to);
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then settle before checking.
  task automatic drive(input bit rst, input bit id, input bit ex, input bit mem,
                       input bit br, input logic [AW-1:0] addr);
    @(posedge clk_in);
    #1;
    reset_in = rst; stallreq_id_in = id; stallreq_ex_in = ex; stallreq_mem_in = mem;
    branch_req_in = br; branch_addr_in = addr;
    #2;
  endtask

  task automatic chk_outs(input string name, input logic [5:0] s, input bit f,
                          input logic [AW-1:0] a);
    chk({name, "_stall"}, 64'(stall_out), 64'(s));
    chk({name, "_flush"}, 64'(jump_flush_out), 64'(f));
    chk({name, "_addr"},  64'(jump_address_out), 64'(a));
  endtask

  initial begin
    // Reset
    drive(1, 0, 0, 0, 0, '0);
    drive(1, 1, 1, 1, 0, '0);
    chk_outs("reset", 6'h00, 0, '0);
    chk("reset_to", 64'(stall_timeout_out), 64'd0);

    // Priority
    drive(0, 1, 0, 0, 0, '0); chk("prio_id",  64'(stall_out), 64'h07);
    drive(0, 1, 1, 0, 0, '0); chk("prio_ex",  64'(stall_out), 64'h0F);
    drive(0, 1, 1, 1, 0, '0); chk("prio_mem", 64'(stall_out), 64'h1F);
    drive(0, 0, 0, 0, 0, '0); chk("prio_rel", 64'(stall_out), 64'h00);

    // Unblocked branch with a wrong-path ID request
    drive(0, 1, 0, 0, 1, 32'h100); chk_outs("ubr", 6'h00, 1, 32'h100);
    drive(0, 0, 0, 0, 0, '0);      chk_outs("ubr_after", 6'h00, 0, '0);

    // Blocked branch under a 5-cycle MEM stall
    drive(0, 0, 0, 1, 1, 32'h200); chk_outs("bbr_c1", 6'h1F, 0, '0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0, '0); chk_outs("bbr_hold", 6'h1F, 0, '0);
    end
    drive(0, 0, 0, 0, 0, '0); chk_outs("bbr_n", 6'h00, 0, '0);
    drive(0, 1, 0, 0, 0, '0); chk_outs("bbr_redir", 6'h00, 1, 32'h200);
    drive(0, 0, 0, 0, 0, '0); chk_outs("bbr_after", 6'h00, 0, '0);

    // Second branch while one is held is ignored
    drive(0, 0, 0, 1, 1, 32'h400); chk_outs("ign_c1", 6'h1F, 0, '0);
    drive(0, 0, 0, 1, 1, 32'h500); chk_outs("ign_c2", 6'h1F, 0, '0);
    drive(0, 0, 0, 0, 0, '0);      chk_outs("ign_n", 6'h00, 0, '0);
    drive(0, 0, 0, 0, 0, '0);      chk_outs("ign_redir", 6'h00, 1, 32'h400);
    drive(0, 0, 0, 0, 0, '0);      chk_outs("ign_after", 6'h00, 0, '0);

    // Reset while a redirect is held discards it
    drive(0, 0, 1, 0, 1, 32'h300); chk_outs("rst_cap", 6'h0F, 0, '0);
    drive(1, 0, 1, 0, 0, '0);      chk_outs("rst_in", 6'h00, 0, '0);
    drive(0, 0, 0, 0, 0, '0);      chk_outs("rst_rel", 6'h00, 0, '0);
    drive(0, 0, 0, 0, 0, '0);      chk_outs("rst_nofl", 6'h00, 0, '0);
    chk("rst_to", 64'(stall_timeout_out), 64'd0);

    // Watchdog: 7 stalled cycles stay below threshold
    for (int i = 0; i < 7; i++) drive(0, 0, 0, 1, 0, '0);
    drive(0, 0, 0, 0, 0, '0); chk("wdt7_a", 64'(stall_timeout_out), 64'd0);
    drive(0, 0, 0, 0, 0, '0); chk("wdt7_b", 64'(stall_timeout_out), 64'd0);
    // 8 stalled cycles reach it; flag appears after the following edge and sticks
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 0, '0);
    drive(0, 0, 0, 0, 0, '0); chk("wdt8_rel", 64'(stall_timeout_out), 64'd0);
    drive(0, 0, 0, 0, 0, '0); chk("wdt8_set", 64'(stall_timeout_out), 64'(WDT));
    drive(0, 0, 0, 0, 0, '0); chk("wdt8_stick", 64'(stall_timeout_out), 64'(WDT));
    drive(1, 0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, 0, '0); chk("wdt_clr", 64'(stall_timeout_out), 64'd0);

    @(posedge clk_in);
    @(negedge clk_in);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the rv32i core. It merges per-stage stall requests into the 6-bit stall vector consumed by pc_reg and the IF/ID/EX/MEM/WB pipeline registers. It issues the jump/flush redirect to pc_reg. When a branch resolves while the pipeline is frozen, it holds the redirect and replays it once the stall releases. It optionally includes a stall watchdog.

## Interface
- ADDR_WIDTH, `ADDR_WIDTH (32): redirect address width.
- MAX_STALL_CYCLES, 1024: watchdog threshold. Only used with the watchdog compiled in.

Ports:
- clk_in  input  1  core clock. Single clock domain.
- reset_in  input  1  synchronous, active-high reset.
- stallreq_id_in  input  1  load-use hazard in ID.
- stallreq_ex_in  input  1  multi-cycle EX operation busy.
- stallreq_mem_in  input  1  data bus not ready.
- branch_req_in  input  1  one-cycle pulse from EX: taken branch or jump resolved.
- branch_addr_in  input  ADDR_WIDTH  target address, valid with branch_req_in.
- stall_out  output  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB. A bit at `STOP means that stage holds.
- jump_flush_out  output  1  redirect strobe to pc_reg; flushes IF/ID.
- jump_address_out  output  ADDR_WIDTH  redirect target.
- stall_timeout_out  output  1  sticky watchdog flag.

## Operation
- Stall vector (combinational), highest requesting stage wins:
  - mem → 6'b011111
  - else ex → 6'b001111
  - else id → 6'b000111
  - else 6'b000000.
- FSM states:
  - RUN:
    - branch_req_in with neither ex nor mem request: assert jump_flush_out and drive jump_address_out = branch_addr_in in the same cycle. Force stall_out bits 2..0 to 0, because the ID load-use request is wrong-path and is dropped. Stay in RUN.
    - branch_req_in while ex or mem is requesting: capture branch_addr_in into pend_addr and go to PEND. No flush this cycle.
  - PEND: stall_out follows the requests. branch_req_in is ignored, since EX is frozen and cannot produce a new branch. When both the ex and mem requests are low, go to REDIR.
  - REDIR: assert jump_flush_out with jump_address_out = pend_addr for exactly one cycle. Force stall_out to 0 regardless of the id request. Return to RUN.
- jump_flush_out is never asserted in two consecutive cycles from a single branch.
- Reset values:
  - stall_out = 0, jump_flush_out = 0, jump_address_out = 0, stall_timeout_out = 0.
  - State = RUN; pend_addr = 0.
- Reset in PEND or REDIR discards the pending redirect; no flush is emitted after reset.
- jump_address_out is 0 whenever jump_flush_out is 0, so the bus is clean for trace.

## Timing
- Unblocked branch: zero-cycle latency. pc_reg loads the target at the next posedge after the branch_req_in cycle.
- Blocked branch:
  - Redirect arrives in the cycle after the last stalled cycle. Cycle N is the first cycle with ex and mem both low; the FSM enters REDIR at edge N+1.
  - During cycle N, stall_out is 0 and pc_reg increments once. This wrong-path fetch is squashed by the flush in N+1.
- Stall vector has zero latency: it follows the stall request inputs combinationally.

## Configuration
- PIPE_CTRL_WDT_EN defined:
  - A saturating counter increments every cycle stall_out != 0 and clears on any cycle with stall_out == 0.
  - When the count reaches MAX_STALL_CYCLES, stall_timeout_out is set at the next edge and stays set until reset_in.
  - The counter width is $clog2(MAX_STALL_CYCLES+1).
- PIPE_CTRL_WDT_EN undefined: no counter is generated and stall_timeout_out is tied to 0.

## Structure
- defines.v (shared):
  - `ADDR_WIDTH and `STOP.
  - Stall vector constants `STALL_NONE, `STALL_ID, `STALL_EX, `STALL_MEM.
- Local to the module: FSM state encodings RUN, PEND, REDIR as 2-bit localparams.
- One sub-module, pipe_stall_wdt (counter plus sticky flag). It is instantiated only under PIPE_CTRL_WDT_EN.

## Test plan
- Priority: after reset, stallreq_id_in=1 → stall_out=6'h07. Adding ex → 6'h0F. Adding mem → 6'h1F. Releasing all → 6'h00 the same cycle.
- Unblocked branch: branch_req_in pulse with addr 32'h0000_0100 and stallreq_id_in=1 → same cycle jump_flush_out=1, jump_address_out=32'h100, stall_out=0. pc_out=32'h100 at the next edge.
- Blocked branch: pulse addr 32'h200 while stallreq_mem_in=1 held 5 cycles → no flush during the stall. Exactly one jump_flush_out with 32'h200 the cycle after release, then none.
- Reset mid-PEND: capture 32'h300 under an ex stall, assert reset_in for 1 cycle, release the stall → no jump_flush_out, and all outputs 0.
- Watchdog (PIPE_CTRL_WDT_EN, MAX_STALL_CYCLES=8):
  - Hold mem 7 cycles → timeout stays 0.
  - Hold mem 8 cycles → stall_timeout_out=1 and stays 1 after the stall drops, until reset.
  - With the macro undefined, the flag stays 0 in the same test.
